io_cfg_loader: RTL
==================

IO_CFG_LOADER -- requirements
Module: io_cfg_loader

Interface
REQ-001 Parameter: NUM_PADS, default 16, is the number of iopad enable bits loaded per frame (legal range 2..64).
REQ-002 Port: CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port: RESETB, input, 1, asynchronous active-low reset.
REQ-004 Port: cfg_start, input, 1, single-cycle request to begin loading a frame.
REQ-005 Port: cfg_valid, input, 1, cfg_bit is valid this cycle.
REQ-006 Port: cfg_bit, input, 1, serial configuration bit; the first bit accepted lands in pad_en[0].
REQ-007 Port: cfg_ready, output, 1, the loader accepts a bit this cycle.
REQ-008 Port: cfg_busy, output, 1, a frame is in progress (SHIFT or COMMIT).
REQ-009 Port: cfg_done, output, 1, one-cycle pulse marking the commit of a frame.
REQ-010 Port: pad_en, output, NUM_PADS, per-pad enable driving the iopad en inputs.
REQ-011 Port: cfg_dout, output, 1, serial readback; present only when IO_CFG_LOADER_READBACK_EN is defined.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, SHIFT and COMMIT, held in a registered state variable.
REQ-013 In IDLE, cfg_start=1 SHALL clear the bit counter and move to SHIFT on the next edge.
REQ-014 cfg_ready SHALL equal 1 only in SHIFT; it is a Moore output with no combinational path from cfg_valid.
REQ-015 A bit is accepted on an edge where cfg_valid=1 and cfg_ready=1.
REQ-016 On acceptance, shift_reg <= {cfg_bit, shift_reg[NUM_PADS-1:1]} and the counter increments, so that after NUM_PADS accepts the first bit sits at index 0.
REQ-017 The counter SHALL be $clog2(NUM_PADS+1) bits wide and SHALL never wrap.
REQ-018 Acceptance of bit number NUM_PADS (counter == NUM_PADS-1) SHALL move the FSM to COMMIT.
REQ-019 In SHIFT, cycles with cfg_valid=0 SHALL hold all state (stall with no timeout).
REQ-020 COMMIT SHALL last exactly one cycle, with cfg_done=1 and cfg_ready=0 in that cycle.
REQ-021 On the edge leaving COMMIT, pad_en <= shift_reg and the FSM returns to IDLE.
REQ-022 The new pad_en is visible from the cycle after cfg_done.
REQ-023 Minimum frame time from the cfg_start cycle to the cfg_done cycle is NUM_PADS+1 cycles.
REQ-024 cfg_start in SHIFT SHALL restart the frame: counter cleared, partial bits discarded, state remains SHIFT, and a bit accepted on the same edge is discarded.
REQ-025 cfg_start in COMMIT SHALL be ignored; the commit completes.
REQ-026 pad_en SHALL change only on the COMMIT exit edge or on reset; partial frames never reach the pads.
REQ-027 cfg_busy SHALL be 1 exactly when the state is SHIFT or COMMIT.

Reset
REQ-028 RESETB=0 SHALL asynchronously force: state IDLE, counter 0, shift_reg 0, pad_en all 0 (all pads disabled), cfg_ready 0, cfg_busy 0, cfg_done 0, cfg_dout 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no cfg_done pulse.
REQ-030 Deassertion SHALL take effect on the next CLK edge; the first cfg_start is honoured from that edge.

Configuration
REQ-031 With IO_CFG_LOADER_READBACK_EN defined, the IDLE->SHIFT transition (and a SHIFT restart) SHALL load shift_reg from pad_en.
REQ-032 With IO_CFG_LOADER_READBACK_EN defined, cfg_dout SHALL equal shift_reg[0], so the old configuration shifts out LSB-first, one bit per accept.
REQ-033 With IO_CFG_LOADER_READBACK_EN undefined, the cfg_dout port and the pad_en->shift_reg load path SHALL be absent, and all other behaviour is identical.

Structure
REQ-034 Package io_cfg_pkg SHALL hold the state enum (IDLE/SHIFT/COMMIT) and the constant IO_CFG_NUM_PADS_DEFAULT = 16.
REQ-035 The shift register plus counter SHALL be one sub-module, io_cfg_shreg; the FSM and pad_en register live in io_cfg_loader.

Verification (NUM_PADS=4)
REQ-036 Reset, then cfg_start, then bits 1,0,1,1 on consecutive cycles -> cfg_done pulses once, 5 cycles after start; pad_en=4'b1101 on the next cycle.
REQ-037 Same frame with cfg_valid=0 for 3 cycles between bits 2 and 3 -> cfg_done delayed by exactly 3 cycles; pad_en=4'b1101; pad_en stays 0 until then.
REQ-038 Start, bits 1,1, cfg_start again, then bits 0,0,1,0 -> pad_en=4'b0100, with one cfg_done.
REQ-039 RESETB pulsed low after 2 of 4 bits, following a prior commit of 4'b1111 -> pad_en=0 immediately, no cfg_done; a new full frame commits normally.
REQ-040 READBACK_EN defined, pad_en=4'b1010, new frame 0,0,0,0 -> cfg_dout sequence 0,1,0,1 on the accepting cycles; pad_en=4'b0000 after commit.
REQ-041 cfg_start asserted during COMMIT -> ignored; FSM returns to IDLE and cfg_busy=0 the following cycle.

Source files
------------

// File: rtl/io_cfg_pkg.sv
// io_cfg_pkg: shared types and constants for the iopad configuration loader.
//   io_cfg_state_t          - loader FSM state encoding (IDLE/SHIFT/COMMIT)
//   IO_CFG_NUM_PADS_DEFAULT - default number of pad enable bits per frame
package io_cfg_pkg;

  localparam int IO_CFG_NUM_PADS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } io_cfg_state_t;

endpackage

// File: rtl/io_cfg_shreg.sv
// io_cfg_shreg: serial-in shift register plus accept counter for one frame.
// Optional feature macro: IO_CFG_LOADER_READBACK_EN (adds load_val, parallel
// load of the current pad configuration on frame start).
// Ports:
//   CLK, RESETB : clock, async active-low reset
//   clr         : frame (re)start; clears the counter and (re)initialises data
//   load_val    : value loaded on clr (readback builds only)
//   shift_en    : accept cfg_bit this edge
//   bit_in      : serial bit, enters at the MSB and walks toward index 0
//   shift_reg   : current register contents
//   last        : the next accept completes the frame
module io_cfg_shreg
  import io_cfg_pkg::*;
#(
  parameter int NUM_PADS = IO_CFG_NUM_PADS_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESETB,
  input  logic                clr,
`ifdef IO_CFG_LOADER_READBACK_EN
  input  logic [NUM_PADS-1:0] load_val,
`endif
  input  logic                shift_en,
  input  logic                bit_in,
  output logic [NUM_PADS-1:0] shift_reg,
  output logic                last
);

  localparam int CW = $clog2(NUM_PADS + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      shift_reg <= '0;
      cnt       <= '0;
    end else if (clr) begin
      cnt <= '0;
`ifdef IO_CFG_LOADER_READBACK_EN
      shift_reg <= load_val;
`else
      shift_reg <= '0;
`endif
    end else if (shift_en) begin
      shift_reg <= {bit_in, shift_reg[NUM_PADS-1:1]};
      // The FSM leaves SHIFT after NUM_PADS accepts, so cnt tops out at
      // NUM_PADS, which the width above always holds.
      cnt       <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(NUM_PADS - 1));

endmodule

// File: rtl/io_cfg_loader.sv
// io_cfg_loader: loads a serial frame of NUM_PADS iopad enable bits and
// commits it to pad_en atomically, so partial frames never reach the pads.
// Optional feature macro: IO_CFG_LOADER_READBACK_EN (adds cfg_dout; the old
// pad_en is shifted out LSB-first while the new frame shifts in).
// Ports:
//   CLK, RESETB : clock, async active-low reset
//   cfg_start   : begin (or restart) a frame
//   cfg_valid   : cfg_bit valid this cycle
//   cfg_bit     : serial data, first accepted bit lands in pad_en[0]
//   cfg_ready   : a bit is accepted this cycle when cfg_valid is high
//   cfg_busy    : frame in progress (SHIFT or COMMIT)
//   cfg_done    : one-cycle pulse in the commit cycle
//   pad_en      : per-pad enables
//   cfg_dout    : serial readback (readback builds only)
//
// state  | meaning
// IDLE   | waiting for cfg_start
// SHIFT  | accepting bits; cfg_start here restarts the frame
// COMMIT | one cycle, cfg_done high; pad_en loads on the exit edge
module io_cfg_loader
  import io_cfg_pkg::*;
#(
  parameter int NUM_PADS = IO_CFG_NUM_PADS_DEFAULT
) (
  input  logic                CLK,
  input  logic                RESETB,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic                cfg_bit,
  output logic                cfg_ready,
  output logic                cfg_busy,
  output logic                cfg_done,
`ifdef IO_CFG_LOADER_READBACK_EN
  output logic                cfg_dout,
`endif
  output logic [NUM_PADS-1:0] pad_en
);

  io_cfg_state_t       state;
  logic                frame_start;
  logic                accept;
  logic                last;
  logic [NUM_PADS-1:0] shift_reg;

  // A start in COMMIT is ignored; a start in SHIFT wins over a same-edge bit.
  assign frame_start = cfg_start && (state == IDLE || state == SHIFT);
  assign accept      = cfg_valid && (state == SHIFT) && !cfg_start;

  assign cfg_ready = (state == SHIFT);
  assign cfg_busy  = (state == SHIFT) || (state == COMMIT);
  assign cfg_done  = (state == COMMIT);

  io_cfg_shreg #(
    .NUM_PADS (NUM_PADS)
  ) u_shreg (
    .CLK       (CLK),
    .RESETB    (RESETB),
    .clr       (frame_start),
`ifdef IO_CFG_LOADER_READBACK_EN
    .load_val  (pad_en),
`endif
    .shift_en  (accept),
    .bit_in    (cfg_bit),
    .shift_reg (shift_reg),
    .last      (last)
  );

`ifdef IO_CFG_LOADER_READBACK_EN
  assign cfg_dout = shift_reg[0];
`endif

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (cfg_start) state <= SHIFT;
        SHIFT:   if (accept && last) state <= COMMIT;
        COMMIT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      pad_en <= '0;
    end else if (state == COMMIT) begin
      pad_en <= shift_reg;
    end
  end

endmodule
